// File: rtl/fft_unload_pkg.sv
// Shared types and helpers for the FFT result unload path.
// This covers the state encoding, the skid FIFO sizing and the bit-reversal helper.
package fft_unload_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_unload_t;

  // Two entries are enough to hide the one-cycle memory read latency at full rate.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam int BITREV_MAX_W = 32;
  localparam int BITREV_SEL_W = $clog2(BITREV_MAX_W);

  // Reverses the low 'width' bits of idx. The bits above 'width' return as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] idx,
                                                     input int width);
    logic [BITREV_MAX_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < width; i++) begin
      rev[BITREV_SEL_W'(i)] = idx[BITREV_SEL_W'(width - 1 - i)];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry FIFO holding result words and their natural-order index.
// It absorbs the read latency between the result memory and the output stream.
module fft_skid_fifo
  import fft_unload_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic [ADDR_W-1:0]     push_idx_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     head_data_o,
  output logic [ADDR_W-1:0]     head_idx_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     idx_q  [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_data_o = data_q[rd_ptr_q];
  assign head_idx_o  = idx_q[rd_ptr_q];

  // NOTE: the storage is reset because the head drives the block outputs, which must read 0 in reset.
  // NOTE: all state here uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data_i;
        idx_q[wr_ptr_q]  <= push_idx_i;
        wr_ptr_q         <= wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_unload_fsm.sv
// Streams the N FFT result words out of the shared result memory in natural order.
// Read addresses are bit-reversed, and a skid FIFO covers the memory latency.
module fft_unload_fsm
  import fft_unload_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int ADDR_W   = $clog2(N_POINTS),
  parameter int DATA_W   = 32,
  parameter bit BITREV   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_idx_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output state_unload_t     state_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int OCC_W = FIFO_CNT_W + 1;
  localparam logic [CNT_W-1:0]  TERM_CNT = CNT_W'(N_POINTS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  state_unload_t         state_q;
  state_unload_t         state_d;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic                  inflight_q;
  logic [ADDR_W-1:0]     inflight_idx_q;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [OCC_W-1:0]      occupancy;

  fft_skid_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (rd_data_i),
    .push_idx_i  (inflight_idx_q),
    .pop_i       (pop),
    .head_data_o (out_data_o),
    .head_idx_o  (out_idx_o),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid_o = ~fifo_empty;
  assign out_last_o  = out_valid_o & (out_idx_o == LAST_IDX);
  assign pop         = out_valid_o & out_ready_i;

  // Words held or already requested, less the one leaving this cycle. This keeps the FIFO from overflowing.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

  assign rd_en_o   = (state_q == STREAM) && (rd_cnt_q < TERM_CNT) &&
                     (occupancy < OCC_W'(FIFO_DEPTH));
  assign rd_addr_o = BITREV ? ADDR_W'(bitrev(BITREV_MAX_W'(rd_cnt_q[ADDR_W-1:0]), ADDR_W))
                            : rd_cnt_q[ADDR_W-1:0];

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = STREAM;
      STREAM:  if (rd_en_o && (rd_cnt_q == LAST_CNT)) state_d = DRAIN;
      // The final beat leaves on this edge, so the FIFO is empty once DONE is entered.
      DRAIN:   if (!inflight_q && pop && out_last_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      rd_cnt_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= rd_en_o;
      inflight_idx_q <= rd_cnt_q[ADDR_W-1:0];
      if ((state_q == IDLE) && start_i) begin
        rd_cnt_q <= '0;
      end else if (rd_en_o) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
                                        inflight_q |-> !fifo_full);

endmodule

// File: tb/tb_fft_unload_fsm.sv
// Scoreboard bench for fft_unload_fsm: bit-reversed and natural instances, with backpressure, stray starts and mid-run reset.
// Expected addresses and beats are queued at start. They are popped as the DUT issues reads and hands over beats.
module tb_fft_unload_fsm;
  import fft_unload_pkg::*;

  localparam int N = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic start;
  logic ready;
  logic sel;

  logic          start_a, rd_en_a, out_valid_a, out_last_a, busy_a, done_a;
  logic [3:0]    rd_addr_a, out_idx_a;
  logic [31:0]   rd_data_a, out_data_a;
  state_unload_t state_a;
  logic          start_b, rd_en_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [3:0]    rd_addr_b, out_idx_b;
  logic [31:0]   rd_data_b, out_data_b;
  state_unload_t state_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  fft_unload_fsm #(.N_POINTS(16), .DATA_W(32), .BITREV(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_a),
    .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a), .rd_data_i(rd_data_a),
    .out_valid_o(out_valid_a), .out_ready_i(ready), .out_data_o(out_data_a),
    .out_idx_o(out_idx_a), .out_last_o(out_last_a), .busy_o(busy_a),
    .done_o(done_a), .state_o(state_a)
  );

  fft_unload_fsm #(.N_POINTS(16), .DATA_W(32), .BITREV(1'b0)) dut_nat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_b),
    .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(ready), .out_data_o(out_data_b),
    .out_idx_o(out_idx_b), .out_last_o(out_last_b), .busy_o(busy_b),
    .done_o(done_b), .state_o(state_b)
  );

  // Result memories with one cycle of read latency
  always @(posedge clk_i) if (rd_en_a) rd_data_a <= 32'hA000_0000 | 32'(rd_addr_a);
  always @(posedge clk_i) if (rd_en_b) rd_data_b <= 32'hA000_0000 | 32'(rd_addr_b);

  always #5 clk_i = ~clk_i;

  logic          m_rd_en, m_valid, m_last, m_busy, m_done;
  logic [3:0]    m_rd_addr, m_idx;
  logic [31:0]   m_data;
  state_unload_t m_state;
  assign m_rd_en   = sel ? rd_en_b     : rd_en_a;
  assign m_rd_addr = sel ? rd_addr_b   : rd_addr_a;
  assign m_valid   = sel ? out_valid_b : out_valid_a;
  assign m_data    = sel ? out_data_b  : out_data_a;
  assign m_idx     = sel ? out_idx_b   : out_idx_a;
  assign m_last    = sel ? out_last_b  : out_last_a;
  assign m_busy    = sel ? busy_b      : busy_a;
  assign m_done    = sel ? done_b      : done_a;
  assign m_state   = sel ? state_b     : state_a;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic ready_at(input int mode, input int c);
    case (mode)
      1:       return !(c >= 6 && c <= 10);
      2:       return (c % 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  logic [3:0] addr_q[$];
  beat_t      sb_q[$];
  bit         mon_en = 1'b0;
  int         ncyc = 0;
  int         base = 0;
  int         cur_mode = 0;
  int         issued, delivered, done_cnt, done_rel, first_valid_rel, last_hs_rel, busy_fall_rel;

  always @(negedge clk_i) begin
    int    rel;
    beat_t exp;
    ncyc++;
    if (mon_en) begin
      rel = ncyc - base;
      check("occupancy_le_2", 64'((issued - delivered) <= 2), 64'd1);
      if (m_rd_en) begin
        if (addr_q.size() == 0) check("extra_read", 64'd1, 64'd0);
        else check("rd_addr", 64'(m_rd_addr), 64'(addr_q.pop_front()));
        issued++;
      end
      if (cur_mode == 2 && ready && delivered < N && rel >= 3)
        check("no_bubble", 64'(m_valid), 64'd1);
      if (m_valid) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (sb_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
        else begin
          exp = sb_q[0];
          check("out_data", 64'(m_data), 64'(exp.data));
          check("out_idx", 64'(m_idx), 64'(exp.idx));
          check("out_last", 64'(m_last), 64'(exp.idx == 4'(N - 1)));
          if (ready) begin
            void'(sb_q.pop_front());
            delivered++;
            last_hs_rel = rel;
          end
        end
      end
      if (m_done) begin
        done_cnt++;
        done_rel = rel;
        check("done_after_last", 64'(rel), 64'(last_hs_rel + 1));
      end
      if (!m_busy && busy_fall_rel < 0 && rel > 0) busy_fall_rel = rel;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  64'(m_rd_en),  64'd0);
    check({tag, "_rd_addr"},64'(m_rd_addr),64'd0);
    check({tag, "_valid"},  64'(m_valid),  64'd0);
    check({tag, "_data"},   64'(m_data),   64'd0);
    check({tag, "_idx"},    64'(m_idx),    64'd0);
    check({tag, "_last"},   64'(m_last),   64'd0);
    check({tag, "_busy"},   64'(m_busy),   64'd0);
    check({tag, "_done"},   64'(m_done),   64'd0);
    check({tag, "_state"},  64'(m_state),  64'(IDLE));
  endtask

  task automatic run_unload(input bit use_nat, input int mode, input int abort_at);
    bit aborted;
    sel = use_nat;
    addr_q.delete();
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      logic [3:0] a;
      a = use_nat ? 4'(i) : rev4(4'(i));
      addr_q.push_back(a);
      sb_q.push_back('{data: 32'hA000_0000 | 32'(a), idx: 4'(i)});
    end
    issued = 0; delivered = 0; done_cnt = 0; done_rel = -1;
    first_valid_rel = -1; last_hs_rel = -1; busy_fall_rel = -1;
    cur_mode = mode;
    aborted = 1'b0;
    @(posedge clk_i); #1;
    base   = ncyc + 1;
    mon_en = 1'b1;
    start  = 1'b1;
    ready  = ready_at(mode, 0);
    for (int c = 1; c < 120; c++) begin
      @(posedge clk_i); #1;
      start = (mode == 3) && (c == 5 || c == 19);
      ready = ready_at(mode, c);
      if (c == abort_at) begin
        rst_i = 1'b1;
        #1;
        check_reset_outputs("abort");
        aborted = 1'b1;
        break;
      end
      if (done_cnt > 0 && c >= done_rel + 3) break;
    end
    start = 1'b0;
    ready = 1'b1;
    if (aborted) begin
      mon_en = 1'b0;
    end else begin
      @(negedge clk_i); #1;
      mon_en = 1'b0;
      check("beats_delivered", 64'(delivered), 64'(N));
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      check("reads_consumed", 64'(addr_q.size()), 64'd0);
      check("idle_after", 64'(m_busy), 64'd0);
      check("state_after", 64'(m_state), 64'(IDLE));
      if (mode == 0 || mode == 3) begin
        check("first_valid_cycle", 64'(first_valid_rel), 64'd3);
        check("done_cycle", 64'(done_rel), 64'd19);
        check("busy_fall_cycle", 64'(busy_fall_rel), 64'd20);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    sel   = 1'b0;
    #1;
    check_reset_outputs("reset");
    #22;
    rst_i = 1'b0;

    run_unload(1'b0, 0, -1);   // bit-reversed, ready high
    run_unload(1'b0, 1, -1);   // ready low for cycles 6-10
    run_unload(1'b0, 2, -1);   // ready toggling
    run_unload(1'b0, 3, -1);   // stray starts in STREAM and DONE
    run_unload(1'b1, 0, -1);   // natural order instance
    run_unload(1'b0, 0, 8);    // reset mid-stream
    @(posedge clk_i); #1;
    check_reset_outputs("held_reset");
    rst_i = 1'b0;
    run_unload(1'b0, 0, -1);   // clean run after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
